bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the calculator's add/sub result register and feeds the 4-digit seven-segment display with decimal digits instead of raw hex nibbles. It accepts one binary operand on a start/ready handshake and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents a registered, stable BCD result plus a one-cycle `done` pulse. Optionally it interprets the operand as two's complement and reports a sign flag for the display's minus segment.

---
 rtl/bin_to_bcd_seq_if.sv | 25 ++
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/ready request and BCD result bundle for bin_to_bcd_seq
//
// Signals:
//   start  : request a conversion of bin (master -> slave)
//   bin    : W-bit binary operand (master -> slave)
//   ready  : converter idle, start will be accepted (slave -> master)
//   done   : one-cycle pulse, new bcd/neg visible (slave -> master)
//   bcd    : 4*DIGITS-bit result, [3:0] = ones digit (slave -> master)
//   neg    : sign of the last result (slave -> master)
interface bin_to_bcd_seq_if #(
   parameter int W      = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [W-1:0]          bin;
   logic                  ready;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;

   modport master (output start, output bin,
                   input  ready, input  done, input bcd, input neg);
   modport slave  (input  start, input  bin,
                   output ready, output done, output bcd, output neg);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
//
// Ports:
//   clk   : rising-edge system clock
//   rst_l : asynchronous active-low reset
//   bus   : bin_to_bcd_seq_if.slave (start, bin, ready, done, bcd, neg)
//
// Optional feature macro: BIN_TO_BCD_SIGNED_EN
//   defined   -> bin is two's complement, magnitude converted, neg reports sign
//   undefined -> bin is unsigned, neg is constant 0
module bin_to_bcd_seq #(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic          clk,
   input  logic          rst_l,
   bin_to_bcd_seq_if.slave bus
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]    state;
   logic [W-1:0]  sr;
   logic [BW-1:0] scr;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bcd_q;
   logic          neg_q;
   logic          done_q;

   logic [BW-1:0] adj;
   logic [BW-1:0] scr_nx;
   logic [W-1:0]  mag;
   logic          sign_in;
   logic          sign_q;

   // Add-3 correction on every digit that would overflow past 9 when doubled.
   always_comb begin
      adj = scr;
      for (int d = 0; d < DIGITS; d++) begin
         if (scr[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
      end
      scr_nx = {adj[BW-2:0], sr[W-1]};
   end

`ifdef BIN_TO_BCD_SIGNED_EN
   // W-bit negation: the most-negative value maps onto itself, which read as
   // unsigned is exactly its magnitude.
   always_comb begin
      sign_in = bus.bin[W-1];
      mag     = sign_in ? (~bus.bin + W'(1)) : bus.bin;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         sign_q <= 1'b0;
      else if (state == IDLE && bus.start)
         sign_q <= sign_in;
   end
`else
   always_comb begin
      sign_in = 1'b0;
      mag     = bus.bin;
      sign_q  = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state  <= IDLE;
         sr     <= '0;
         scr    <= '0;
         cnt    <= '0;
         bcd_q  <= '0;
         neg_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sr    <= mag;
                  scr   <= '0;
                  cnt   <= CW'(W);
                  state <= SHIFT;
               end
            end
            default: begin
               scr <= scr_nx;
               sr  <= {sr[W-2:0], 1'b0};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  // Result register is only written here, so the display
                  // never sees partially converted scratch digits.
                  bcd_q  <= scr_nx;
                  neg_q  <= sign_q;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.ready = (state == IDLE);
   assign bus.done  = done_q;
   assign bus.bcd   = bcd_q;
   assign bus.neg   = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst_l;
   int   tests;
   int   fails;

   bin_to_bcd_seq_if #(.W(8), .DIGITS(3)) bus ();

   bin_to_bcd_seq #(.W(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Call at a negedge; returns one edge after the accepting edge E0.
   task automatic start_conv(input logic [7:0] v);
      bus.start = 1'b1;
      bus.bin   = v;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Returns the index of the edge after E0 at which done is seen, 0 if never.
   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic conv(input string tag, input logic [7:0] v,
                       input logic [11:0] exp_bcd, input logic exp_neg);
      int n;
      @(negedge clk);
      start_conv(v);
      wait_done(n);
      check({tag, "_latency"}, n, 8);
      check({tag, "_bcd"}, {20'd0, bus.bcd}, {20'd0, exp_bcd});
      check({tag, "_neg"}, {31'd0, bus.neg}, {31'd0, exp_neg});
      check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
   endtask

   initial begin
      int n;
      int dones;
      int bad;
      tests = 0;
      fails = 0;
      rst_l     = 1'b0;
      bus.start = 1'b0;
      bus.bin   = '0;

      // Reset state
      #3;
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_done",  {31'd0, bus.done},  32'd0);
      check("rst_bcd",   {20'd0, bus.bcd},   32'h000);
      check("rst_neg",   {31'd0, bus.neg},   32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("idle_dones", dones, 0);
      check("idle_ready", {31'd0, bus.ready}, 32'd1);
      check("idle_bcd",   {20'd0, bus.bcd},   32'h000);

      // Busy rejection: second start during SHIFT must be dropped
      start_conv(8'd37);
      dones = 0;
      bad   = 0;
      n     = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) begin
            bus.start = 1'b1;
            bus.bin   = 8'd200;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (bus.done) begin
            dones++;
            if (n == 0) n = i;
         end
         if (dones == 0 && bus.bcd !== 12'h000) bad++;
      end
      check("busy_latency", n, 8);
      check("busy_dones", dones, 1);
      check("busy_hold", bad, 0);
      check("busy_bcd", {20'd0, bus.bcd}, 32'h037);

`ifdef BIN_TO_BCD_SIGNED_EN
      conv("s80", 8'h80, 12'h128, 1'b1);
      conv("sF6", 8'hF6, 12'h010, 1'b1);
      conv("s7F", 8'h7F, 12'h127, 1'b0);
      conv("s00", 8'h00, 12'h000, 1'b0);
      conv("sFF", 8'hFF, 12'h001, 1'b1);
`else
      conv("uFF", 8'hFF, 12'h255, 1'b0);
      conv("u00", 8'd0,  12'h000, 1'b0);
      conv("u99", 8'd99, 12'h099, 1'b0);
      conv("u100", 8'd100, 12'h100, 1'b0);
      conv("uF6", 8'hF6, 12'h246, 1'b0);
`endif

      // Back-to-back: new start in the done cycle
      @(negedge clk);
      start_conv(8'd250);
      wait_done(n);
      check("b2b_first_latency", n, 8);
`ifdef BIN_TO_BCD_SIGNED_EN
      check("b2b_first_bcd", {20'd0, bus.bcd}, 32'h006);
`else
      check("b2b_first_bcd", {20'd0, bus.bcd}, 32'h250);
`endif
      start_conv(8'd12);
      check("b2b_busy", {31'd0, bus.ready}, 32'd0);
      wait_done(n);
      check("b2b_second_latency", n, 8);
      check("b2b_second_bcd", {20'd0, bus.bcd}, 32'h012);

      // Mid-conversion reset
      @(negedge clk);
      start_conv(8'd255);
      repeat (4) @(posedge clk);
      #2 rst_l = 1'b0;
      #1;
      check("mrst_ready", {31'd0, bus.ready}, 32'd1);
      check("mrst_done",  {31'd0, bus.done},  32'd0);
      check("mrst_bcd",   {20'd0, bus.bcd},   32'h000);
      check("mrst_neg",   {31'd0, bus.neg},   32'd0);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      rst_l = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("mrst_no_done", dones, 0);
      check("mrst_bcd_after", {20'd0, bus.bcd}, 32'h000);
      conv("mrst_42", 8'd42, 12'h042, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
